axis_demux: RTL
===============

AXIS_DEMUX -- requirements
Module: axis_demux

Interface
REQ-001 Parameter: DATA_WIDTH, default 256, width of all TDATA buses in bits.
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 AXIS_IN_TDATA  input  DATA_WIDTH  input stream data.
REQ-005 AXIS_IN_TVALID  input  1  input beat valid.
REQ-006 AXIS_IN_TLAST  input  1  last beat of input packet.
REQ-007 AXIS_IN_TDEST  input  1  destination select, 0 = OUT1, 1 = OUT2; meaningful on first beat only.
REQ-008 AXIS_IN_TREADY  output  1  input beat accepted when high with TVALID.
REQ-009 AXIS_OUT1_TDATA / AXIS_OUT1_TVALID / AXIS_OUT1_TLAST  output  DATA_WIDTH/1/1  output stream 1.
REQ-010 AXIS_OUT1_TREADY  input  1  output stream 1 ready.
REQ-011 AXIS_OUT2_TDATA / AXIS_OUT2_TVALID / AXIS_OUT2_TLAST  output  DATA_WIDTH/1/1  output stream 2.
REQ-012 AXIS_OUT2_TREADY  input  1  output stream 2 ready.
REQ-013 PKT_COUNT1, PKT_COUNT2  output  16 each  packets completed on OUT1/OUT2.

Function
REQ-014 Input beat transfers on a rising edge where AXIS_IN_TVALID and AXIS_IN_TREADY are both high; output beat transfers where its TVALID and TREADY are both high.
REQ-015 Routing FSM has two states: SOP (next accepted beat starts a packet) and MID (inside a packet).
REQ-016 In SOP, an accepted beat latches AXIS_IN_TDEST as the packet destination; state goes to MID unless that beat has TLAST high, in which case state stays SOP.
REQ-017 In MID, the destination is held; AXIS_IN_TDEST is ignored; an accepted beat with TLAST high returns state to SOP.
REQ-018 Datapath is a 2-entry skid buffer (output register plus skid register), each entry holding TDATA, TLAST and destination.
REQ-019 AXIS_IN_TREADY is a registered signal, high exactly when the skid register is empty; no combinational path from any OUTn_TREADY to AXIS_IN_TREADY.
REQ-020 Latency: a beat accepted at edge N appears on its destination output from the cycle after edge N when the output register is empty or draining at edge N.
REQ-021 Sustained throughput is one beat per cycle while the destination output holds TREADY high.
REQ-022 Only the output named by the output-register entry's destination drives TVALID high; the other output's TVALID is 0.
REQ-023 Both OUTn_TDATA and OUTn_TLAST are driven from the output register; the values are don't-care when TVALID is low.
REQ-024 Once OUTn_TVALID is high, TDATA/TLAST hold stable until transfer (AXIS rule).
REQ-025 The output stalls with TREADY low on the destination output. Buffer fills to 2 entries and AXIS_IN_TREADY drops. No beat is lost, duplicated or reordered.
REQ-026 Back-to-back packets to different destinations: the first beat of the new packet is not presented until the prior beat has transferred (strict in-order, no bypass).
REQ-027 PKT_COUNTn increments by 1 on each OUTn transfer with TLAST high; it wraps 0xFFFF -> 0x0000.
REQ-028 Zero-length packets do not exist; a single beat with TLAST high is a 1-beat packet and counts once.

Reset
REQ-029 While reset is high: AXIS_IN_TREADY=0, OUT1/OUT2 TVALID=0, TLAST=0, TDATA=0, PKT_COUNT1/2=0, both buffer entries empty, FSM = SOP.
REQ-030 AXIS_IN_TREADY goes high on the first rising edge after reset deasserts.
REQ-031 Reset mid-packet discards all buffered beats and the partial packet; the next accepted beat is treated as SOP.

Structure
REQ-032 A shared package holds the FSM state enumeration (SOP, MID), the destination encodings (DEST_OUT1=0, DEST_OUT2=1) and the counter width (16).
REQ-033 The skid buffer is a sub-module named axis_skid_buf, parameterised by payload width, and is reused by the FSM/routing wrapper.

Verification
REQ-034 Reset, then a 4-beat packet with TDEST=0 and data 1..4, with OUT1_TREADY held at 1 -> OUT1 carries 1..4 on consecutive cycles with TLAST on 4; OUT2_TVALID stays 0; PKT_COUNT1=1.
REQ-035 A 3-beat packet with TDEST=1 on beat 0 and TDEST=0 on beats 1-2 -> all 3 beats go to OUT2; PKT_COUNT2=1.
REQ-036 Continuous input with OUT1_TREADY low for 5 cycles -> exactly 2 beats are buffered; AXIS_IN_TREADY is 0 from the cycle after the buffer fills; on release, data emerges complete and in order.
REQ-037 Alternating 1-beat packets with TDEST 0,1,0,1 -> they appear on OUT1, OUT2, OUT1, OUT2; PKT_COUNT1=2 and PKT_COUNT2=2.
REQ-038 Preload PKT_COUNT1 to 0xFFFF by sending 65535 packets, then send one more -> PKT_COUNT1=0x0000.
REQ-039 Assert reset after beat 2 of a 5-beat packet -> all outputs are at their reset values; a new 2-beat packet with TDEST=1 then routes to OUT2 correctly.

Source files
------------

// File: rtl/axis_demux_pkg.sv
// Shared types and constants for the AXI-Stream 1:2 demultiplexer.
package axis_demux_pkg;

  typedef enum logic {
    SOP = 1'b0,
    MID = 1'b1
  } state_e;

  localparam logic DEST_OUT1 = 1'b0;
  localparam logic DEST_OUT2 = 1'b1;

  localparam int CNT_W = 16;
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry skid buffer (output register plus skid register) for a generic payload.
// s_ready is a flop, so no combinational path exists from m_ready back to s_ready.
module axis_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready
);

  logic [W-1:0] out_data_q, out_data_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         out_valid_q, out_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic         ready_q, ready_d;
  logic         in_fire;
  logic         out_free;

  assign in_fire  = s_valid & ready_q;
  assign out_free = ~out_valid_q | m_ready;

  // NOTE: every variable gets its hold value first, so no branch can leave it unassigned and infer a latch.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (out_free) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_valid_d = 1'b1;
        out_data_d  = s_data;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_data_d  = s_data;
    end
    ready_d = ~skid_valid_d;
  end

  // NOTE: the data registers are reset as well, because the outputs must read zero while in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      ready_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples pre-edge values regardless of statement order.
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      ready_q      <= ready_d;
    end
  end

  assign s_ready = ready_q;
  assign m_valid = out_valid_q;
  assign m_data  = out_data_q;

endmodule

// File: rtl/axis_demux.sv
// AXI-Stream 1:2 packet demultiplexer: TDEST on the first beat steers the whole packet.
// Beats pass in order through one shared skid buffer; per-output completed-packet counters.
module axis_demux
  import axis_demux_pkg::*;
#(
  parameter int DATA_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] AXIS_IN_TDATA,
  input  logic                  AXIS_IN_TVALID,
  input  logic                  AXIS_IN_TLAST,
  input  logic                  AXIS_IN_TDEST,
  output logic                  AXIS_IN_TREADY,
  output logic [DATA_WIDTH-1:0] AXIS_OUT1_TDATA,
  output logic                  AXIS_OUT1_TVALID,
  output logic                  AXIS_OUT1_TLAST,
  input  logic                  AXIS_OUT1_TREADY,
  output logic [DATA_WIDTH-1:0] AXIS_OUT2_TDATA,
  output logic                  AXIS_OUT2_TVALID,
  output logic                  AXIS_OUT2_TLAST,
  input  logic                  AXIS_OUT2_TREADY,
  output logic [CNT_W-1:0]      PKT_COUNT1,
  output logic [CNT_W-1:0]      PKT_COUNT2
);

  localparam int   PW      = DATA_WIDTH + 2;
  localparam cnt_t CNT_ONE = cnt_t'(1);

  state_e          state_q, state_d;
  logic            dest_q, dest_d;
  cnt_t            cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic            in_fire;
  logic            beat_dest;
  logic [PW-1:0]   s_payload, m_payload;
  logic            m_valid, m_ready;
  logic            out_dest, out_last;
  logic [DATA_WIDTH-1:0] out_data;
  logic            out1_fire, out2_fire;

  assign in_fire   = AXIS_IN_TVALID & AXIS_IN_TREADY;
  assign beat_dest = (state_q == SOP) ? AXIS_IN_TDEST : dest_q;
  assign s_payload = {beat_dest, AXIS_IN_TLAST, AXIS_IN_TDATA};

  axis_skid_buf #(.W(PW)) u_skid (
    .clk     (clk),
    .rst     (reset),
    .s_data  (s_payload),
    .s_valid (AXIS_IN_TVALID),
    .s_ready (AXIS_IN_TREADY),
    .m_data  (m_payload),
    .m_valid (m_valid),
    .m_ready (m_ready)
  );

  assign out_dest = m_payload[PW-1];
  assign out_last = m_payload[DATA_WIDTH];
  assign out_data = m_payload[DATA_WIDTH-1:0];

  // The destination travels with each beat, so the head beat alone selects the live output.
  assign m_ready          = (out_dest == DEST_OUT1) ? AXIS_OUT1_TREADY : AXIS_OUT2_TREADY;
  assign AXIS_OUT1_TVALID = m_valid & (out_dest == DEST_OUT1);
  assign AXIS_OUT2_TVALID = m_valid & (out_dest == DEST_OUT2);
  assign AXIS_OUT1_TDATA  = out_data;
  assign AXIS_OUT2_TDATA  = out_data;
  assign AXIS_OUT1_TLAST  = out_last;
  assign AXIS_OUT2_TLAST  = out_last;

  assign out1_fire = AXIS_OUT1_TVALID & AXIS_OUT1_TREADY;
  assign out2_fire = AXIS_OUT2_TVALID & AXIS_OUT2_TREADY;

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    if (in_fire) begin
      case (state_q)
        SOP: begin
          dest_d  = AXIS_IN_TDEST;
          state_d = AXIS_IN_TLAST ? SOP : MID;
        end
        MID: begin
          if (AXIS_IN_TLAST) state_d = SOP;
        end
      endcase
    end
  end

  always_comb begin
    cnt1_d = cnt1_q;
    cnt2_d = cnt2_q;
    if (out1_fire && out_last) cnt1_d = cnt1_q + CNT_ONE;
    if (out2_fire && out_last) cnt2_d = cnt2_q + CNT_ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SOP;
      dest_q  <= DEST_OUT1;
      cnt1_q  <= '0;
      cnt2_q  <= '0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
    end
  end

  assign PKT_COUNT1 = cnt1_q;
  assign PKT_COUNT2 = cnt2_q;

endmodule
